code_event_fifo: RTL

CODE_EVENT_FIFO -- requirements
Module: code_event_fifo

---
 rtl/code_event_fifo.sv | 82 ++++++++
 1 files changed

// File: rtl/code_event_fifo.sv
// code_event_fifo: debounced 8-to-3 priority-encoder event capture into a FWFT FIFO
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   code_n, ex_n, s_n    raw active-low outputs of the upstream encoder
//   rd_ready             consumer accepts the head entry
//   clr_ovf              synchronous clear of the sticky overflow flag
//   rd_valid, rd_chan    head entry valid and its active-high line index
//   fifo_count           occupied entries
//   overflow             an event was dropped while the FIFO was full
//   idle                 filtered encoder state is enabled with no line active
module code_event_fifo #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 code_n,
  input  logic                       ex_n,
  input  logic                       s_n,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [2:0]                 rd_chan,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // vectors are {code_n, ex_n, s_n}; all-ones is the DISABLED state
  logic [4:0] sync1_q, sync2_q, prev_q, stable_q;
  logic [3:0] cnt_q, cnt_d;
  logic same, load, push_q, push_d, idle_q, ovf_q, pop, full, wr, drop;
  logic [2:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q, count_d;
  assign same = sync2_q == prev_q;
  assign cnt_d = !same ? 4'd0 : (cnt_q == 4'(STABLE_CYCLES-1) ? cnt_q : cnt_q + 4'd1);
  // load exactly once per run, on the edge the counter steps onto STABLE_CYCLES-1
  assign load = same && cnt_q == 4'(STABLE_CYCLES-2);
  // event only when entering ACTIVE or changing channel while ACTIVE
  assign push_d = load && !sync2_q[1] && (stable_q[1] || stable_q[4:2] != sync2_q[4:2]);
  assign rd_valid = count_q != '0;
  assign pop = rd_valid && rd_ready;
  assign full = count_q == CW'(DEPTH);
  assign wr = push_q && (!full || pop);
  assign drop = push_q && full && !pop;
  assign count_d = (wr && !pop) ? count_q + CW'(1) : ((!wr && pop) ? count_q - CW'(1) : count_q);
  assign rd_chan = rd_valid ? mem_q[rp_q] : 3'd0;
  assign fifo_count = count_q;
  assign overflow = ovf_q;
  assign idle = idle_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q <= '1;
      stable_q <= '1;
      cnt_q <= '0;
      push_q <= 1'b0;
      idle_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sync1_q <= {code_n, ex_n, s_n};
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      cnt_q <= cnt_d;
      if (load) stable_q <= sync2_q;
      push_q <= push_d;
      idle_q <= stable_q[1:0] == 2'b10;
      if (wr) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      count_q <= count_d;
      ovf_q <= drop | (ovf_q & ~clr_ovf);
    end
  // stable_q still holds the value that raised the event when push_q writes it
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= ~stable_q[4:2];
endmodule
